mem_stage: RTL and testbench

Memory-access stage directly downstream of the execute stage. It accepts one ALU result per transaction, together with store data and memory control. Loads and stores go to data memory over a valid/ready request channel and a valid-only response channel; non-memory results pass straight through. Each transaction retires as a single writeback beat to the register-file writeback stage.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: op/size encodings, FSM states, lane constants.
package mem_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  // A half must sit on an even byte, a word on a word boundary.
  function automatic logic is_misaligned(mem_size_e size, logic [OFF_W-1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobe/data replication and load extract/extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [OFF_W-1:0]  st_off_i,
  input  logic [1:0]        st_size_i,
  input  logic [WORD_W-1:0] st_data_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_unsigned_i,
  input  logic [WORD_W-1:0] ld_word_i,
  output logic [LANES-1:0]  wstrb_c,
  output logic [WORD_W-1:0] wdata_c,
  output logic [WORD_W-1:0] ldata_c
);

  logic [15:0] ld_half;
  logic        ld_sign;

  always_comb begin
    wstrb_c = '1;
    wdata_c = st_data_i;
    case (mem_size_e'(st_size_i))
      SZ_BYTE: begin
        wstrb_c = LANES'(4'b0001 << st_off_i);
        wdata_c = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        wstrb_c = LANES'(4'b0011 << st_off_i);
        wdata_c = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lanes shifted past the top of the word fall away as zeros.
  always_comb begin
    ld_half = 16'(ld_word_i >> {ld_off_i, 3'b000});
    ld_sign = 1'b0;
    ldata_c = ld_word_i;
    case (mem_size_e'(ld_size_i))
      SZ_BYTE: begin
        ld_sign = ~ld_unsigned_i & ld_half[7];
        ldata_c = {{24{ld_sign}}, ld_half[7:0]};
      end
      SZ_HALF: begin
        ld_sign = ~ld_unsigned_i & ld_half[15];
        ldata_c = {{16{ld_sign}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX result in, dmem request/response, single writeback beat out.
// Optional alignment faulting is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [4:0]        rd_addr,
  input  logic              rd_we,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [LANES-1:0]  dmem_wstrb,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  state_e            state_q, state_d;
  logic              store_q, store_d;
  mem_size_e         size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic              dwe_q, dwe_d;
  logic [LANES-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              mis_q, mis_d;

  logic [LANES-1:0]  st_strb_c;
  logic [DATA_W-1:0] st_data_c;
  logic [DATA_W-1:0] ld_data_c;
  logic              bad_align_c;
  mem_op_e           in_op_c;

  mem_lane_align u_lane (
    .st_off_i      (alu_result[1:0]),
    .st_size_i     (mem_size),
    .st_data_i     (rs2_data),
    .ld_off_i      (addr_q[1:0]),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_word_i     (dmem_rsp_rdata),
    .wstrb_c       (st_strb_c),
    .wdata_c       (st_data_c),
    .ldata_c       (ld_data_c)
  );

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign in_op_c  = mem_op_e'(mem_op);

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align_c = is_misaligned(mem_size_e'(mem_size), alu_result[1:0]);
`else
  assign bad_align_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      req_valid_q <= 1'b0;
      daddr_q     <= '0;
      dwe_q       <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_data_q   <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      req_valid_q <= req_valid_d;
      daddr_q     <= daddr_d;
      dwe_q       <= dwe_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      wb_data_q   <= wb_data_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    req_valid_d = req_valid_q;
    daddr_d     = daddr_q;
    dwe_d       = dwe_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    wb_data_d   = wb_data_q;
    mis_d       = mis_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          store_d = (in_op_c == OP_STORE);
          size_d  = mem_size_e'(mem_size);
          uns_d   = mem_unsigned;
          addr_d  = alu_result;
          rd_d    = rd_addr;
          rd_we_d = rd_we;
          if (in_op_c == OP_LOAD || in_op_c == OP_STORE) begin
            if (bad_align_c) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = rd_addr;
              wb_we_d    = 1'b0;
              wb_data_d  = alu_result;
              mis_d      = 1'b1;
            end else begin
              state_d     = S_REQ;
              req_valid_d = 1'b1;
              daddr_d     = ADDR_W'({alu_result[ADDR_W-1:2], 2'b00});
              dwe_d       = (in_op_c == OP_STORE);
              wstrb_d     = (in_op_c == OP_STORE) ? st_strb_c : '0;
              wdata_d     = (in_op_c == OP_STORE) ? st_data_c : '0;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_addr;
            wb_we_d    = rd_we;
            wb_data_d  = alu_result;
            mis_d      = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          if (store_q) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_we_d    = 1'b0;
            wb_data_d  = addr_q;
            mis_d      = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = rd_we_q;
          wb_data_d  = ld_data_c;
          mis_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = daddr_q;
  assign dmem_we        = dwe_q;
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd_addr     = wb_rd_q;
  assign wb_we          = wb_we_q;
  assign wb_data        = wb_data_q;
  assign misalign       = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed transactions push expected beats, monitors pop and compare.
module tb_mem_stage;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] STORE = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;
  localparam logic [1:0] BYTE  = 2'b00;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] WORD  = 2'b10;
  localparam logic [1:0] WORD3 = 2'b11;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        chk_lanes;
  } req_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2_data = '0;
  logic [1:0]  mem_op = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_unsigned = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic        rd_we = 1'b0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        misalign;

  int checks = 0;
  int passes = 0;
  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  wb_exp_t  mw;
  req_exp_t mr;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .rs2_data       (rs2_data),
    .mem_op         (mem_op),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .rd_addr        (rd_addr),
    .rd_we          (rd_we),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .wb_valid       (wb_valid),
    .wb_rd_addr     (wb_rd_addr),
    .wb_we          (wb_we),
    .wb_data        (wb_data),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Writeback and request-channel monitors.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          mw = wb_q.pop_front();
          check("wb_rd_addr", 32'(wb_rd_addr), 32'(mw.rd));
          check("wb_we", 32'(wb_we), 32'(mw.we));
          if (mw.chk_data) check("wb_data", wb_data, mw.data);
          check("wb_misalign", 32'(misalign), 32'(mw.mis));
        end
      end
      if (dmem_req_valid) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 32'(dmem_req_valid), 32'd0);
        end else begin
          mr = req_q[0];
          check("req_addr", dmem_addr, mr.addr);
          check("req_we", 32'(dmem_we), 32'(mr.we));
          if (mr.chk_lanes) begin
            check("req_wstrb", 32'(dmem_wstrb), 32'(mr.strb));
            check("req_wdata", dmem_wdata, mr.wdata);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && dmem_req_valid && dmem_req_ready && req_q.size() != 0) void'(req_q.pop_front());
  end

  task automatic send(input logic [1:0] op, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] rs2,
                      input logic [4:0] rd, input logic we, input int stall, input int rsp_dly,
                      input logic [31:0] rdata, input logic [3:0] exp_strb,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_data, input logic exp_mis);
    wb_exp_t  w;
    req_exp_t r;
    logic     is_mem;
    int       n;
    is_mem = (op == LOAD) || (op == STORE);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_op = op; mem_size = size; mem_unsigned = uns;
    alu_result = addr; rs2_data = rs2; rd_addr = rd; rd_we = we;
    if (is_mem && !exp_mis) begin
      r = '{addr: {addr[31:2], 2'b00}, we: (op == STORE), strb: exp_strb,
            wdata: exp_wdata, chk_lanes: (op == STORE)};
      req_q.push_back(r);
    end
    w = '{rd: rd, we: (op == STORE || exp_mis) ? 1'b0 : we, data: exp_data,
          chk_data: (op != STORE) || exp_mis, mis: exp_mis};
    wb_q.push_back(w);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!is_mem || exp_mis) begin
      @(negedge clk);
      check("wb_in_cycle1", 32'(wb_valid), 32'd1);
      if (exp_mis) check("mis_no_req", 32'(dmem_req_valid), 32'd0);
    end else begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_req_valid", 32'(dmem_req_valid), 32'd1);
      end
      @(negedge clk);
      check("req_valid", 32'(dmem_req_valid), 32'd1);
      dmem_req_ready = 1'b1;
      @(posedge clk);
      #1 dmem_req_ready = 1'b0;
      if (op == LOAD) begin
        for (int i = 0; i < rsp_dly; i++) begin
          @(negedge clk);
          check("wait_no_wb", 32'(wb_valid), 32'd0);
          check("wait_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
        @(posedge clk);
        #1 dmem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      check("wb_after_mem", 32'(wb_valid), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    send(NONE,  WORD, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_1234, 1'b0);
    send(STORE, BYTE, 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 5'd7, 1'b1, 0, 0, 32'h0, 4'b1000, 32'hDDDD_DDDD, 32'h0, 1'b0);
    send(LOAD,  HALF, 1'b0, 32'h0000_2002, 32'h0, 5'd10, 1'b1, 0, 0, 32'h8001_1234, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0);
    send(LOAD,  HALF, 1'b1, 32'h0000_2002, 32'h0, 5'd11, 1'b1, 0, 0, 32'h8001_1234, 4'h0, 32'h0, 32'h0000_8001, 1'b0);
    send(STORE, WORD, 1'b0, 32'h0000_3000, 32'h1234_5678, 5'd12, 1'b1, 3, 0, 32'h0, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
    send(STORE, HALF, 1'b0, 32'h0000_4002, 32'h0000_BEEF, 5'd13, 1'b1, 0, 0, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
    send(LOAD,  BYTE, 1'b0, 32'h0000_5001, 32'h0, 5'd14, 1'b1, 0, 1, 32'h1122_8344, 4'h0, 32'h0, 32'hFFFF_FF83, 1'b0);
    send(LOAD,  WORD, 1'b0, 32'h0000_6000, 32'h0, 5'd9, 1'b1, 2, 2, 32'hCAFE_F00D, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
    send(NONE,  BYTE, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b0, 0, 0, 32'h0, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    send(RSVD,  BYTE, 1'b0, 32'h0000_0055, 32'h0, 5'd1, 1'b1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_0055, 1'b0);
    send(LOAD,  BYTE, 1'b1, 32'h0000_5003, 32'h0, 5'd15, 1'b1, 0, 0, 32'h9A00_0000, 4'h0, 32'h0, 32'h0000_009A, 1'b0);
    send(LOAD,  WORD3, 1'b0, 32'h0000_6004, 32'h0, 5'd16, 1'b1, 0, 0, 32'h8000_0001, 4'h0, 32'h0, 32'h8000_0001, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    send(LOAD,  WORD, 1'b0, 32'h0000_1002, 32'h0, 5'd17, 1'b1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_1002, 1'b1);
    send(STORE, HALF, 1'b0, 32'h0000_7003, 32'h0000_BEEF, 5'd18, 1'b1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_7003, 1'b1);
`else
    send(STORE, HALF, 1'b0, 32'h0000_7003, 32'h0000_BEEF, 5'd18, 1'b1, 0, 0, 32'h0, 4'b1000, 32'hBEEF_BEEF, 32'h0, 1'b0);
    send(LOAD,  HALF, 1'b0, 32'h0000_7003, 32'h0, 5'd19, 1'b1, 0, 0, 32'hAB00_0000, 4'h0, 32'h0, 32'h0000_00AB, 1'b0);
`endif

    // Abandon a load in WAIT with a reset pulse; the late response must not retire.
    check("rst_test_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_op = LOAD; mem_size = WORD; mem_unsigned = 1'b0;
    alu_result = 32'h0000_8000; rd_addr = 5'd3; rd_we = 1'b1;
    req_q.push_back('{addr: 32'h0000_8000, we: 1'b0, strb: 4'h0, wdata: 32'h0, chk_lanes: 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk);
    #1 dmem_req_ready = 1'b0;
    @(negedge clk);
    check("wait_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_misalign", 32'(misalign), 32'd0);
    check("midrst_dmem_addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_no_wb", 32'(wb_valid), 32'd0);
    check("late_rsp_in_ready", 32'(in_ready), 32'd1);

    repeat (3) @(negedge clk);
    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
